// File: rtl/demo.sv
// demo: enable-gated up-counter with step, terminal value and prescaler; count drives out directly.
// Latency: one clock edge from a qualified enable to an updated out (PRESCALE=1); out is a register.
// Backpressure: none; no handshake. enable=0 freezes both count and prescale phase.
// Build option: define DEMO_SATURATE_EN to saturate at MAX_VALUE instead of wrapping to 0.
module demo #(
    parameter int WIDTH     = 8,
    parameter int STEP      = 1,
    parameter int MAX_VALUE = 255,
    parameter int PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] out
);

    // Prescale counter needs at least one bit even when PRESCALE is 1.
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    // Threshold held one bit wider than the count so cnt+STEP never has to be formed to decide a wrap.
    localparam logic [WIDTH:0]   LIMIT    = (WIDTH + 1)'(MAX_VALUE - STEP);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VALUE);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             evt;

    // Next-state: advance the prescaler on enabled edges and step the count on each prescale rollover.
    always_comb begin
        cnt_d = cnt_q;
        pre_d = pre_q;
        evt   = 1'b0;

        if (enable) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                evt   = 1'b1;
            end else begin
                pre_d = pre_q + PRE_ONE;
            end
        end

        if (evt) begin
            if ({1'b0, cnt_q} > LIMIT) begin
`ifdef DEMO_SATURATE_EN
                // Once at the top the same branch reloads MAX_VALUE, so it sticks until reset.
                cnt_d = MAX_W;
`else
                cnt_d = '0;
`endif
            end else begin
                cnt_d = cnt_q + STEP_W;
            end
        end
    end

    // State registers with synchronous reset that overrides enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            pre_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            pre_q <= pre_d;
        end
    end

    assign out = cnt_q;

endmodule

// File: tb/tb_demo.sv
// tb_demo: drives a default demo and a STEP=3/MAX_VALUE=10/PRESCALE=2 demo from one phase table.
// Per-edge expectations come from a closed-form model (events since reset) via a scoreboard queue;
// phase endpoints are also checked against hand-computed table constants.
module tb_demo;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] out_a;
    logic [3:0] out_b;

    int n_cmp;
    int n_bad;

`ifdef DEMO_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    demo u_dut_a (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .out    (out_a)
    );

    demo #(
        .WIDTH     (4),
        .STEP      (3),
        .MAX_VALUE (10),
        .PRESCALE  (2)
    ) u_dut_b (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .out    (out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic en;
        int   cyc;
        int   a_wrap;
        int   a_sat;
        int   b_wrap;
        int   b_sat;
    } vec_t;

    localparam int NV = 16;
    vec_t vec [NV];

    int sb_a [$];
    int sb_b [$];

    int ev_a;
    int en_b;

    task automatic check(input string name, input int idx, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s step=%0d got=%0d want=%0d at %0t", name, idx, got, want, $time);
        end
    endtask

    initial begin
        int step_no;
        int ea;
        int eb;
        int evb;

        n_cmp   = 0;
        n_bad   = 0;
        ev_a    = 0;
        en_b    = 0;
        step_no = 0;

        //            rst   en    cyc  a_wr a_sat b_wr b_sat
        vec[0]  = '{1'b1, 1'b0,   2,   0,   0,  0,  0};   // reset hold
        vec[1]  = '{1'b0, 1'b0,   1,   0,   0,  0,  0};   // released, still idle
        vec[2]  = '{1'b0, 1'b1, 100, 100, 100,  6, 10};   // out=100 at 1030 ns
        vec[3]  = '{1'b0, 1'b1, 155, 255, 255,  9, 10};   // reach terminal
        vec[4]  = '{1'b0, 1'b1,   1,   0, 255,  0, 10};   // wrap / saturate
        vec[5]  = '{1'b0, 1'b1,  42,  42, 255,  3, 10};
        vec[6]  = '{1'b1, 1'b1,   1,   0,   0,  0,  0};   // reset mid-count wins over enable
        vec[7]  = '{1'b0, 1'b1,   2,   2,   2,  3,  3};   // resumes 1,2
        vec[8]  = '{1'b0, 1'b1,   8,  10,  10,  3, 10};
        vec[9]  = '{1'b0, 1'b0,   5,  10,  10,  3, 10};   // enable gating
        vec[10] = '{1'b0, 1'b1,   1,  11,  11,  3, 10};
        vec[11] = '{1'b0, 1'b1,   1,  12,  12,  6, 10};   // prescale phase kept across gap
        vec[12] = '{1'b0, 1'b1,   1,  13,  13,  6, 10};   // leaves B prescaler mid-phase
        vec[13] = '{1'b1, 1'b0,   1,   0,   0,  0,  0};   // reset must clear prescaler
        vec[14] = '{1'b0, 1'b1,   1,   1,   1,  0,  0};
        vec[15] = '{1'b0, 1'b1,   1,   2,   2,  3,  3};

        reset  = 1'b1;
        enable = 1'b0;

        for (int p = 0; p < NV; p++) begin
            for (int c = 0; c < vec[p].cyc; c++) begin
                reset  = vec[p].rst;
                enable = vec[p].en;

                // Model the effect of the coming rising edge.
                if (vec[p].rst) begin
                    ev_a = 0;
                    en_b = 0;
                end else if (vec[p].en) begin
                    ev_a++;
                    en_b++;
                end
                evb = en_b / 2;
                if (SAT) begin
                    ea = (ev_a > 255) ? 255 : ev_a;
                    eb = (evb >= 4) ? 10 : evb * 3;
                end else begin
                    ea = ev_a % 256;
                    eb = (evb % 4) * 3;
                end
                sb_a.push_back(ea);
                sb_b.push_back(eb);

                @(negedge clk);
                step_no++;

                if (sb_a.size() == 0 || sb_b.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scoreboard_empty step=%0d got=0 want=1", step_no);
                end else begin
                    check("edge_out_a", step_no, int'(out_a), sb_a.pop_front());
                    check("edge_out_b", step_no, int'(out_b), sb_b.pop_front());
                end
            end

            check("phase_out_a", p, int'(out_a), SAT ? vec[p].a_sat : vec[p].a_wrap);
            check("phase_out_b", p, int'(out_b), SAT ? vec[p].b_sat : vec[p].b_wrap);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
